// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared constants for the ForthCPU register file
package register_file_pkg;

    // Byte/word select carried on BYTEX from the register sequencer
    localparam logic BYTEX_WORD = 1'b0;
    localparam logic BYTEX_BYTE = 1'b1;

    // Register index width for the default 16-entry file
    localparam int REG_IDX_W = 4;

endpackage

// File: rtl/byte_lane_merge.sv
// rtl/byte_lane_merge.sv - next-value word for one register from both write ports
module byte_lane_merge #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] old_value,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    input  logic             a_write,
    input  logic             b_write,
    input  logic             byte_mode,
    input  logic             high_lane,
    output logic [WIDTH-1:0] next_value
);

    localparam int HALF = WIDTH / 2;

    // Port B lays down a full word first; port A then overrides only the lanes it owns
    always_comb begin
        next_value = old_value;
        if (b_write) begin
            next_value = din_b;
        end
        if (a_write) begin
            if (!byte_mode) begin
                next_value = din_a;
            end else if (high_lane) begin
                next_value[WIDTH-1:HALF] = din_a[HALF-1:0];
            end else begin
                next_value[HALF-1:0] = din_a[HALF-1:0];
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - dual-port general register file with registered read data
module register_file
    import register_file_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       REGA_EN,
    input  logic                       REGA_WEN,
    input  logic                       REGB_EN,
    input  logic                       REGB_WEN,
    input  logic                       BYTEX,
    input  logic                       A0,
    input  logic [$clog2(NREGS)-1:0]   ARGA,
    input  logic [$clog2(NREGS)-1:0]   ARGB,
    input  logic [WIDTH-1:0]           DIN_A,
    input  logic [WIDTH-1:0]           DIN_B,
    output logic [WIDTH-1:0]           DOUT_A,
    output logic [WIDTH-1:0]           DOUT_B
);

    localparam int IDX_W = $clog2(NREGS);

    logic [WIDTH-1:0] regs      [NREGS];
    logic [WIDTH-1:0] next_regs [NREGS];

    logic wr_a;
    logic wr_b;
    logic rd_a;
    logic rd_b;
    logic byte_mode;

    assign wr_a      = REGA_EN & REGA_WEN;
    assign wr_b      = REGB_EN & REGB_WEN;
    assign rd_a      = REGA_EN & ~REGA_WEN;
    assign rd_b      = REGB_EN & ~REGB_WEN;
    assign byte_mode = (BYTEX == BYTEX_BYTE);

    // One merge per register so collisions resolve without any priority mux at the array
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        byte_lane_merge #(
            .WIDTH(WIDTH)
        ) u_merge (
            .old_value (regs[i]),
            .din_a     (DIN_A),
            .din_b     (DIN_B),
            .a_write   (wr_a && (ARGA == IDX_W'(i))),
            .b_write   (wr_b && (ARGB == IDX_W'(i))),
            .byte_mode (byte_mode),
            .high_lane (A0),
            .next_value(next_regs[i])
        );
    end

    // Register array update; reset clears every entry so an in-flight write is discarded
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= next_regs[i];
            end
        end
    end

    // Read capture reads the pre-write array, so a same-edge write on the other port is not bypassed
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DOUT_A <= '0;
            DOUT_B <= '0;
        end else begin
            if (rd_a) begin
                DOUT_A <= regs[ARGA];
            end
            if (rd_b) begin
                DOUT_B <= regs[ARGB];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
module tb_register_file;
    import register_file_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        REGA_EN = 1'b0;
    logic        REGA_WEN = 1'b0;
    logic        REGB_EN = 1'b0;
    logic        REGB_WEN = 1'b0;
    logic        BYTEX = BYTEX_WORD;
    logic        A0 = 1'b0;
    logic [3:0]  ARGA = 4'd0;
    logic [3:0]  ARGB = 4'd0;
    logic [15:0] DIN_A = 16'h0000;
    logic [15:0] DIN_B = 16'h0000;
    logic [15:0] DOUT_A;
    logic [15:0] DOUT_B;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    localparam logic W = BYTEX_WORD;
    localparam logic B = BYTEX_BYTE;

    register_file #(.NREGS(16), .WIDTH(16)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .REGA_EN (REGA_EN),
        .REGA_WEN(REGA_WEN),
        .REGB_EN (REGB_EN),
        .REGB_WEN(REGB_WEN),
        .BYTEX   (BYTEX),
        .A0      (A0),
        .ARGA    (ARGA),
        .ARGB    (ARGB),
        .DIN_A   (DIN_A),
        .DIN_B   (DIN_B),
        .DOUT_A  (DOUT_A),
        .DOUT_B  (DOUT_B)
    );

    always #5 CLK = ~CLK;

    task automatic push_exp(input logic [15:0] ea, input logic [15:0] eb, input string nm);
        exp_t t;
        t.a = ea;
        t.b = eb;
        t.name = nm;
        q.push_back(t);
    endtask

    task automatic drive(input logic aen, input logic awen, input logic ben, input logic bwen,
                         input logic bx, input logic a0v, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [15:0] da, input logic [15:0] db);
        REGA_EN = aen;
        REGA_WEN = awen;
        REGB_EN = ben;
        REGB_WEN = bwen;
        BYTEX = bx;
        A0 = a0v;
        ARGA = ra;
        ARGB = rb;
        DIN_A = da;
        DIN_B = db;
    endtask

    task automatic idle_inputs();
        REGA_EN = 1'b0;
        REGA_WEN = 1'b0;
        REGB_EN = 1'b0;
        REGB_WEN = 1'b0;
    endtask

    // One edge with the given strobes; expected DOUT values after that edge are hand-computed
    task automatic cyc(input logic aen, input logic awen, input logic ben, input logic bwen,
                       input logic bx, input logic a0v, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [15:0] da, input logic [15:0] db,
                       input logic [15:0] ea, input logic [15:0] eb, input string nm);
        drive(aen, awen, ben, bwen, bx, a0v, ra, rb, da, db);
        @(posedge CLK);
        #1;
        push_exp(ea, eb, nm);
        idle_inputs();
    endtask

    // Monitor: compares DUT outputs on the falling edge against the oldest pending expectation
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            total++;
            if (DOUT_A !== mon_e.a) begin
                bad++;
                $display("FAIL %s DOUT_A actual=%h required=%h", mon_e.name, DOUT_A, mon_e.a);
            end
            total++;
            if (DOUT_B !== mon_e.b) begin
                bad++;
                $display("FAIL %s DOUT_B actual=%h required=%h", mon_e.name, DOUT_B, mon_e.b);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held: everything zero
        repeat (2) @(posedge CLK);
        #1;
        push_exp(16'h0000, 16'h0000, "reset_hold");
        @(negedge CLK);
        #1;
        RESET = 1'b1;

        // R3 = BEEF, read back, then reset lands mid-COMMIT of a second write
        cyc(1, 1, 0, 0, W, 0, 4'd3, 4'd0, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, "wr_r3");
        cyc(1, 0, 1, 0, W, 0, 4'd3, 4'd3, 16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF, "rd_r3");
        drive(1, 1, 0, 0, W, 0, 4'd3, 4'd0, 16'h1111, 16'h0000);
        @(negedge CLK);
        #1;
        RESET = 1'b0;
        push_exp(16'h0000, 16'h0000, "rst_mid_commit");
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        idle_inputs();
        cyc(1, 0, 1, 0, W, 0, 4'd3, 4'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "rd_r3_after_rst");

        // word write / read on both ports
        cyc(1, 1, 0, 0, W, 0, 4'd5, 4'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, "wr_r5");
        cyc(1, 0, 1, 0, W, 0, 4'd5, 4'd5, 16'h0000, 16'h0000, 16'h1234, 16'h1234, "rd_r5");

        // byte lanes on R7
        cyc(0, 0, 1, 1, W, 0, 4'd0, 4'd7, 16'h0000, 16'hAABB, 16'h1234, 16'h1234, "wr_r7_word");
        cyc(1, 1, 0, 0, B, 0, 4'd7, 4'd0, 16'h5511, 16'h0000, 16'h1234, 16'h1234, "wr_r7_lo");
        cyc(1, 0, 0, 0, W, 0, 4'd7, 4'd0, 16'h0000, 16'h0000, 16'hAA11, 16'h1234, "rd_r7_lo");
        cyc(1, 1, 0, 0, B, 1, 4'd7, 4'd0, 16'h6622, 16'h0000, 16'hAA11, 16'h1234, "wr_r7_hi");
        cyc(0, 0, 1, 0, W, 0, 4'd7, 4'd7, 16'h0000, 16'h0000, 16'hAA11, 16'h2211, "rd_r7_hi");

        // both ports write different registers; DOUT held through COMMIT
        cyc(1, 1, 1, 1, W, 0, 4'd2, 4'd4, 16'h5555, 16'h0102, 16'hAA11, 16'h2211, "lda_upb_commit");
        cyc(1, 0, 1, 0, W, 0, 4'd2, 4'd4, 16'h0000, 16'h0000, 16'h5555, 16'h0102, "rd_r2_r4");

        // collisions on R6
        cyc(1, 1, 1, 1, B, 1, 4'd6, 4'd6, 16'h00CC, 16'h1234, 16'h5555, 16'h0102, "coll_hi");
        cyc(1, 0, 0, 0, W, 0, 4'd6, 4'd0, 16'h0000, 16'h0000, 16'hCC34, 16'h0102, "rd_coll_hi");
        cyc(1, 1, 1, 1, B, 0, 4'd6, 4'd6, 16'h00EE, 16'h5678, 16'hCC34, 16'h0102, "coll_lo");
        cyc(0, 0, 1, 0, W, 0, 4'd0, 4'd6, 16'h0000, 16'h0000, 16'hCC34, 16'h56EE, "rd_coll_lo");
        cyc(1, 1, 1, 1, W, 0, 4'd6, 4'd6, 16'h9999, 16'h1111, 16'hCC34, 16'h56EE, "coll_word");
        cyc(1, 0, 0, 0, W, 0, 4'd6, 4'd0, 16'h0000, 16'h0000, 16'h9999, 16'h56EE, "rd_coll_word");

        // strobes without enable do nothing; read without enable does not capture
        cyc(0, 1, 0, 1, W, 0, 4'd6, 4'd5, 16'hFFFF, 16'hFFFF, 16'h9999, 16'h56EE, "ign_wen");
        cyc(0, 0, 0, 0, W, 0, 4'd5, 4'd2, 16'h0000, 16'h0000, 16'h9999, 16'h56EE, "no_en_hold");
        cyc(1, 0, 1, 0, W, 0, 4'd6, 4'd5, 16'h0000, 16'h0000, 16'h9999, 16'h1234, "rd_after_ign");

        // read-during-write on the other port returns the pre-write value
        cyc(1, 1, 1, 0, W, 0, 4'd5, 4'd5, 16'hABCD, 16'h0000, 16'h9999, 16'h1234, "rdw_old");
        cyc(1, 0, 0, 0, W, 0, 4'd5, 4'd0, 16'h0000, 16'h0000, 16'hABCD, 16'h1234, "rdw_new");

        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(posedge CLK);
        end
        @(posedge CLK);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Dual-port 16×16-bit general register file for the ForthCPU datapath. It sits directly downstream of the register sequencer and consumes its REGA_EN/REGA_WEN/REGB_EN/REGB_WEN strobes together with BYTEX and A0. It provides registered A/B operands to the ALU and address path during DECODE/EXECUTE. At COMMIT it writes back a word or byte result to RA and a word update (pointer increment/decrement) to RB.

## Interface
Parameters:
- NREGS, 16, number of registers; index width is log2(NREGS).
- WIDTH, 16, register width; must be even (two byte lanes).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset; one clock domain only.
- REGA_EN  in  1  port A enabled, from the register sequencer.
- REGA_WEN  in  1  port A write strobe; effective only when REGA_EN=1.
- REGB_EN  in  1  port B enabled.
- REGB_WEN  in  1  port B write strobe; effective only when REGB_EN=1.
- BYTEX  in  1  `BYTEX_WORD` / `BYTEX_BYTE`; affects port A writes only.
- A0  in  1  byte lane select for port A byte writes: 0 = low byte, 1 = high byte.
- ARGA  in  4  port A register index.
- ARGB  in  4  port B register index.
- DIN_A  in  16  port A write data; byte writes take DIN_A[7:0].
- DIN_B  in  16  port B write data; always a full word.
- DOUT_A  out  16  registered port A read data.
- DOUT_B  out  16  registered port B read data.

## Operation
- Read capture:
  - On a rising edge with REGA_EN=1 and REGA_WEN=0, DOUT_A <= R[ARGA]. Otherwise DOUT_A holds.
  - Port B is identical, using REGB_EN, REGB_WEN, ARGB and DOUT_B.
- Write A: on a rising edge with REGA_EN=1 and REGA_WEN=1:
  - BYTEX=word: R[ARGA] <= DIN_A.
  - BYTEX=byte, A0=0: R[ARGA][7:0] <= DIN_A[7:0]; upper byte unchanged.
  - BYTEX=byte, A0=1: R[ARGA][15:8] <= DIN_A[7:0]; lower byte unchanged.
- Write B: on a rising edge with REGB_EN=1 and REGB_WEN=1, R[ARGB] <= DIN_B. BYTEX and A0 are ignored.
- Ignored strobes: a WEN asserted without its EN has no effect. No register changes, and the corresponding DOUT holds.
- Collision: if both ports write and ARGA==ARGB, port A wins for the lanes it writes. For an A byte write, the other lane takes DIN_B's byte. The net result is a merge of DIN_B with the A byte lane.
- Read-during-write: DOUT ports do not capture during their own write cycle. Read capture on the other port in the same edge returns the pre-write value (no bypass).
- All registers, including R0, are general purpose; there are no hardwired constants.

## Timing
- Reset: while RESET=0, all R[i]=16'h0000, DOUT_A=16'h0000 and DOUT_B=16'h0000, asynchronously. Release is synchronous to the next rising edge.
- Read latency: DOUT is valid 1 cycle after the EN-qualified edge. With the sequencer, the edge that ends DECODE loads DOUT, and DOUT is refreshed at the edge ending EXECUTE.
- DOUT is held through COMMIT, because WEN=1 suppresses capture.
- Write latency: R[] is updated at the edge ending COMMIT. The new value is visible on DOUT from the DECODE capture of the next instruction.
- Reset mid-instruction aborts any pending write. No partial byte/word write is ever retained.
- All inputs are sampled only at rising edges. No combinational path exists from any input to DOUT_A/DOUT_B.

## Structure
- `BYTEX_WORD`, `BYTEX_BYTE` and the register index width come from the shared constants.v. No new typedefs are needed.
- One sub-module, byte_lane_merge, is combinational. It produces the next-value word from the old value, DIN_A, DIN_B, the BYTEX/A0 lane mask and the collision select. It is instantiated once per write-target evaluation.
- The register array and both DOUT registers live in register_file itself.

## Test plan
- Reset: write R3=16'hBEEF, then pulse RESET low mid-COMMIT -> R3, DOUT_A and DOUT_B all read 16'h0000 after release.
- Word write/read:
  - A write, ARGA=5, DIN_A=16'h1234, BYTEX word, at COMMIT.
  - Next instruction reads ARGA=5 and ARGB=5 -> DOUT_A=DOUT_B=16'h1234 one cycle after DECODE.
- Byte lanes:
  - Start with R7=16'hAABB.
  - Byte write, A0=0, DIN_A=16'h0011 -> R7=16'hAA11.
  - Then A0=1, DIN_A=16'h0022 -> R7=16'h2211.
- LDA_UPB: ARGA=2, ARGB=4, DIN_A=16'h5555, DIN_B=16'h0102, both WEN at COMMIT -> R2=16'h5555, R4=16'h0102, and DOUT held throughout COMMIT.
- Collision:
  - Setup: ARGA=ARGB=6, byte write A0=1, DIN_A=16'h00CC, DIN_B=16'h1234, both WEN.
  - Expected: R6=16'hCC34.
  - Word write with DIN_A=16'h9999 -> R6=16'h9999.
- Ignored strobes: REGA_WEN=1 with REGA_EN=0 and DIN_A=16'hFFFF -> R[ARGA] unchanged and DOUT_A holds its previous value.
